iig_rect_sum: RTL and testbench

- Reader side of the integral-image buffer that the integral image generator fills.
- Accepts a rectangle request (x, y, w, h) inside the current detection window and issues four corner reads to the integral-image RAM.
- Returns rect sum = D - B - C + A for the Haar-feature evaluators downstream.
- The integral-image RAM is zero-padded: row 0 and column 0 hold 0, so corners never need negative coordinates.

---
 rtl/iig_rect_sum_if.sv | 31 +++
 rtl/iig_rect_sum.sv | 148 ++++++++++++++
 tb/tb_iig_rect_sum.sv | 264 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/iig_rect_sum_if.sv
// Rectangle-sum request/result bus plus the integral-image RAM read port.
interface iig_rect_sum_if #(
  parameter int unsigned DATA_W  = 21,
  parameter int unsigned COORD_W = 5,
  parameter int unsigned ADDR_W  = 10
);
  logic               iStart;
  logic [COORD_W-1:0] iX;
  logic [COORD_W-1:0] iY;
  logic [COORD_W-1:0] iW;
  logic [COORD_W-1:0] iH;
  logic               oReady;
  logic               oRdEn;
  logic [ADDR_W-1:0]  oRdAddr;
  logic [DATA_W-1:0]  iRdData;
  logic               oValid;
  logic [DATA_W-1:0]  oSum;
  logic               oErr;

  // Requester side: issues rectangles, serves RAM reads, consumes results.
  modport master (
    output iStart, iX, iY, iW, iH, iRdData,
    input  oReady, oRdEn, oRdAddr, oValid, oSum, oErr
  );

  // Rectangle-sum engine side.
  modport slave (
    input  iStart, iX, iY, iW, iH, iRdData,
    output oReady, oRdEn, oRdAddr, oValid, oSum, oErr
  );
endinterface

// File: rtl/iig_rect_sum.sv
// Integral-image rectangle sum: four corner reads, sum = D - B - C + A.
module iig_rect_sum #(
  parameter int unsigned DATA_W  = 21,
  parameter int unsigned IMG_W   = 24,
  parameter int unsigned IMG_H   = 24,
  parameter int unsigned COORD_W = 5,
  parameter int unsigned ADDR_W  = 10,
  parameter int unsigned RD_LAT  = 1
) (
  input logic          iClk,
  input logic          iReset_n,
  iig_rect_sum_if.slave bus
);

  localparam logic [ADDR_W-1:0]  STRIDE = ADDR_W'(IMG_W + 1);
  localparam logic [COORD_W:0]   MAX_X  = (COORD_W+1)'(IMG_W);
  localparam logic [COORD_W:0]   MAX_Y  = (COORD_W+1)'(IMG_H);

  typedef enum logic [2:0] {IDLE, RD_A, RD_B, RD_C, RD_D, WAIT, ERR} state_t;

  state_t             state;
  logic               ready;
  logic               rdEn;
  logic [ADDR_W-1:0]  rdAddr;
  logic               valid;
  logic [DATA_W-1:0]  sum;
  logic               err;
  logic [DATA_W-1:0]  acc;
  logic [DATA_W-1:0]  accNext;
  logic [ADDR_W-1:0]  addrA;
  logic [ADDR_W-1:0]  rowOff;
  logic [ADDR_W-1:0]  wOff;
  logic [1:0]         corner;
  // Tag per in-flight read: {valid, corner index}
  logic [2:0]         tagPipe [RD_LAT];

  logic [COORD_W:0]   xEnd;
  logic [COORD_W:0]   yEnd;
  logic               reqErr;
  logic [ADDR_W-1:0]  reqAddrA;
  logic [2:0]         retTag;

  assign bus.oReady  = ready;
  assign bus.oRdEn   = rdEn;
  assign bus.oRdAddr = rdAddr;
  assign bus.oValid  = valid;
  assign bus.oSum    = sum;
  assign bus.oErr    = err;

  assign xEnd     = {1'b0, bus.iX} + {1'b0, bus.iW};
  assign yEnd     = {1'b0, bus.iY} + {1'b0, bus.iH};
  assign reqErr   = (bus.iW == '0) || (bus.iH == '0) || (xEnd > MAX_X) || (yEnd > MAX_Y);
  assign reqAddrA = ADDR_W'(bus.iY) * STRIDE + ADDR_W'(bus.iX);
  assign retTag   = tagPipe[RD_LAT-1];

  // Signed accumulation of the corner currently on the read-data bus (B and C subtract).
  always_comb begin
    accNext = acc;
    if (retTag[2]) begin
      if (retTag[1:0] == 2'd1 || retTag[1:0] == 2'd2)
        accNext = acc - bus.iRdData;
      else
        accNext = acc + bus.iRdData;
    end
  end

  // Request FSM, read issue, return tracking and result registers.
  always_ff @(posedge iClk) begin
    if (!iReset_n) begin
      state  <= IDLE;
      ready  <= 1'b1;
      rdEn   <= 1'b0;
      rdAddr <= '0;
      valid  <= 1'b0;
      sum    <= '0;
      err    <= 1'b0;
      acc    <= '0;
      addrA  <= '0;
      rowOff <= '0;
      wOff   <= '0;
      corner <= '0;
      for (int unsigned i = 0; i < RD_LAT; i++) tagPipe[i] <= '0;
    end else begin
      valid      <= 1'b0;
      acc        <= accNext;
      tagPipe[0] <= {rdEn, corner};
      for (int unsigned i = 1; i < RD_LAT; i++) tagPipe[i] <= tagPipe[i-1];

      case (state)
        IDLE: begin
          if (bus.iStart) begin
            ready <= 1'b0;
            acc   <= '0;
            if (reqErr) begin
              state <= ERR;
            end else begin
              state  <= RD_A;
              rdEn   <= 1'b1;
              rdAddr <= reqAddrA;
              addrA  <= reqAddrA;
              rowOff <= ADDR_W'(bus.iH) * STRIDE;
              wOff   <= ADDR_W'(bus.iW);
              corner <= 2'd0;
            end
          end
        end
        RD_A: begin
          rdAddr <= rdAddr + wOff;
          corner <= 2'd1;
          state  <= RD_B;
        end
        RD_B: begin
          rdAddr <= addrA + rowOff;
          corner <= 2'd2;
          state  <= RD_C;
        end
        RD_C: begin
          rdAddr <= rdAddr + wOff;
          corner <= 2'd3;
          state  <= RD_D;
        end
        RD_D: begin
          rdEn  <= 1'b0;
          state <= WAIT;
        end
        WAIT: begin
          // D is the last corner; its return completes the sum.
          if (retTag[2] && retTag[1:0] == 2'd3) begin
            sum   <= accNext;
            valid <= 1'b1;
            err   <= 1'b0;
            ready <= 1'b1;
            state <= IDLE;
          end
        end
        ERR: begin
          sum   <= '0;
          valid <= 1'b1;
          err   <= 1'b1;
          ready <= 1'b1;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_iig_rect_sum.sv
// Directed bench for iig_rect_sum: one instance with RD_LAT=1, one with RD_LAT=3.
module tb_iig_rect_sum;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rstN;
  logic       sel;      // 0: RD_LAT=1 instance, 1: RD_LAT=3 instance
  logic       start;
  logic [4:0] rx, ry, rw, rh;
  int         mode;     // memory content selector
  int         compared = 0;
  int         mismatched = 0;

  localparam logic [20:0] JUNK = 21'h15A5A;

  iig_rect_sum_if #(.DATA_W(21), .COORD_W(5), .ADDR_W(10)) bus1 ();
  iig_rect_sum_if #(.DATA_W(21), .COORD_W(5), .ADDR_W(10)) bus3 ();

  iig_rect_sum #(.DATA_W(21), .IMG_W(24), .IMG_H(24), .COORD_W(5), .ADDR_W(10), .RD_LAT(1))
    dut1 (.iClk(clk), .iReset_n(rstN), .bus(bus1));
  iig_rect_sum #(.DATA_W(21), .IMG_W(24), .IMG_H(24), .COORD_W(5), .ADDR_W(10), .RD_LAT(3))
    dut3 (.iClk(clk), .iReset_n(rstN), .bus(bus3));

  assign bus1.iStart = start & ~sel;
  assign bus3.iStart = start & sel;
  assign bus1.iX = rx;  assign bus1.iY = ry;  assign bus1.iW = rw;  assign bus1.iH = rh;
  assign bus3.iX = rx;  assign bus3.iY = ry;  assign bus3.iW = rw;  assign bus3.iH = rh;

  // Integral-image RAM contents, row stride 25, zero row/column 0.
  function automatic logic [20:0] memVal(input int m, input logic [9:0] a);
    int r, c;
    r = int'(a) / 25;
    c = int'(a) % 25;
    case (m)
      0: return 21'(r * c);
      1: return 21'(255 * r * c);
      default: begin
        if (a == 10'd27) return 21'h1FFFFD;
        if (a == 10'd52) return 21'd5;
        return 21'd0;
      end
    endcase
  endfunction

  logic [20:0] rd1, d0, d1, d2;
  assign bus1.iRdData = rd1;
  assign bus3.iRdData = d2;

  // RAM models with one and three cycles of read latency; junk when not reading.
  always @(posedge clk) begin
    rd1 <= bus1.oRdEn ? memVal(mode, bus1.oRdAddr) : JUNK;
    d0  <= bus3.oRdEn ? memVal(mode, bus3.oRdAddr) : JUNK;
    d1  <= d0;
    d2  <= d1;
  end

  logic        cReady, cRdEn, cValid, cErr;
  logic [9:0]  cAddr;
  logic [20:0] cSum;
  assign cReady = sel ? bus3.oReady  : bus1.oReady;
  assign cRdEn  = sel ? bus3.oRdEn   : bus1.oRdEn;
  assign cValid = sel ? bus3.oValid  : bus1.oValid;
  assign cErr   = sel ? bus3.oErr    : bus1.oErr;
  assign cAddr  = sel ? bus3.oRdAddr : bus1.oRdAddr;
  assign cSum   = sel ? bus3.oSum    : bus1.oSum;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Issue one valid request from an idle cycle; returns in the oValid cycle.
  task automatic doReq(input string name, input logic [4:0] x, y, w, h,
                       input logic [9:0] a0, a1, a2, a3, input logic [20:0] expSum,
                       input int lat, input bit hold);
    logic [9:0] exp [4];
    exp = '{a0, a1, a2, a3};
    rx = x; ry = y; rw = w; rh = h;
    start = 1'b1;
    tick();
    if (!hold) start = 1'b0;
    for (int k = 0; k < 4; k++) begin
      compared++;
      if (cRdEn !== 1'b1 || cAddr !== exp[k]) begin
        mismatched++;
        $display("FAIL %s read%0d: got en=%0b addr=%0d want en=1 addr=%0d", name, k, cRdEn, cAddr, exp[k]);
      end
      compared++;
      if (cReady !== 1'b0 || cValid !== 1'b0) begin
        mismatched++;
        $display("FAIL %s busy%0d: got ready=%0b valid=%0b want 0 0", name, k, cReady, cValid);
      end
      tick();
    end
    for (int k = 0; k < lat; k++) begin
      compared++;
      if (cRdEn !== 1'b0 || cAddr !== a3 || cValid !== 1'b0) begin
        mismatched++;
        $display("FAIL %s wait%0d: got en=%0b addr=%0d valid=%0b want 0 %0d 0", name, k, cRdEn, cAddr, cValid, a3);
      end
      tick();
    end
    compared++;
    if (cValid !== 1'b1 || cErr !== 1'b0 || cSum !== expSum || cReady !== 1'b1) begin
      mismatched++;
      $display("FAIL %s result: got valid=%0b err=%0b sum=%0d ready=%0b want 1 0 %0d 1",
               name, cValid, cErr, cSum, cReady, expSum);
    end
    start = 1'b0;
  endtask

  // Check that the previous result pulse ended and the sum is held.
  task automatic checkPulseEnd(input string name, input logic [20:0] expSum);
    tick();
    compared++;
    if (cValid !== 1'b0 || cSum !== expSum) begin
      mismatched++;
      $display("FAIL %s pulse: got valid=%0b sum=%0d want 0 %0d", name, cValid, cSum, expSum);
    end
  endtask

  task automatic test_reset();
    rstN = 1'b0; start = 1'b0; sel = 1'b0; mode = 0;
    rx = '0; ry = '0; rw = '0; rh = '0;
    repeat (3) tick();
    for (int s = 0; s < 2; s++) begin
      sel = s[0];
      #1;
      compared++;
      if (cReady !== 1'b1 || cRdEn !== 1'b0 || cAddr !== 10'd0 ||
          cValid !== 1'b0 || cSum !== 21'd0 || cErr !== 1'b0) begin
        mismatched++;
        $display("FAIL reset%0d: got rdy=%0b en=%0b addr=%0d v=%0b sum=%0d err=%0b want 1 0 0 0 0 0",
                 s, cReady, cRdEn, cAddr, cValid, cSum, cErr);
      end
    end
    sel = 1'b0;
    rstN = 1'b1;
    tick();
  endtask

  task automatic test_single();
    mode = 0; sel = 1'b0;
    doReq("single", 5'd2, 5'd3, 5'd4, 5'd5, 10'd77, 10'd81, 10'd202, 10'd206, 21'd20, 1, 1'b0);
    checkPulseEnd("single", 21'd20);
  endtask

  task automatic test_full();
    mode = 1; sel = 1'b0;
    doReq("full", 5'd0, 5'd0, 5'd24, 5'd24, 10'd0, 10'd24, 10'd600, 10'd624, 21'd146880, 1, 1'b0);
    checkPulseEnd("full", 21'd146880);
  endtask

  task automatic test_wrap();
    mode = 2; sel = 1'b0;
    doReq("wrap", 5'd1, 5'd1, 5'd1, 5'd1, 10'd26, 10'd27, 10'd51, 10'd52, 21'd8, 1, 1'b0);
    checkPulseEnd("wrap", 21'd8);
  endtask

  task automatic doErr(input string name, input logic [4:0] x, y, w, h);
    rx = x; ry = y; rw = w; rh = h;
    start = 1'b1;
    tick();
    start = 1'b0;
    compared++;
    if (cRdEn !== 1'b0 || cValid !== 1'b0 || cReady !== 1'b0) begin
      mismatched++;
      $display("FAIL %s accept: got en=%0b valid=%0b ready=%0b want 0 0 0", name, cRdEn, cValid, cReady);
    end
    tick();
    compared++;
    if (cValid !== 1'b1 || cErr !== 1'b1 || cSum !== 21'd0 || cReady !== 1'b1 || cRdEn !== 1'b0) begin
      mismatched++;
      $display("FAIL %s result: got v=%0b err=%0b sum=%0d rdy=%0b en=%0b want 1 1 0 1 0",
               name, cValid, cErr, cSum, cReady, cRdEn);
    end
    checkPulseEnd(name, 21'd0);
  endtask

  task automatic test_oob();
    mode = 0; sel = 1'b0;
    doErr("oob_x", 5'd20, 5'd0, 5'd5, 5'd1);
    tick();
    doErr("oob_h0", 5'd0, 5'd0, 5'd3, 5'd0);
    tick();
  endtask

  task automatic test_hold_start();
    mode = 0; sel = 1'b0;
    doReq("hold", 5'd2, 5'd3, 5'd4, 5'd5, 10'd77, 10'd81, 10'd202, 10'd206, 21'd20, 1, 1'b1);
    checkPulseEnd("hold", 21'd20);
    compared++;
    if (cRdEn !== 1'b0 || cReady !== 1'b1) begin
      mismatched++;
      $display("FAIL hold idle: got en=%0b ready=%0b want 0 1", cRdEn, cReady);
    end
  endtask

  task automatic test_back_to_back();
    mode = 0; sel = 1'b0;
    tick();
    doReq("b2b_1", 5'd2, 5'd3, 5'd4, 5'd5, 10'd77, 10'd81, 10'd202, 10'd206, 21'd20, 1, 1'b0);
    doReq("b2b_2", 5'd0, 5'd0, 5'd3, 5'd2, 10'd0, 10'd3, 10'd50, 10'd53, 21'd6, 1, 1'b0);
    checkPulseEnd("b2b_2", 21'd6);
  endtask

  task automatic test_reset_mid();
    mode = 0; sel = 1'b0;
    tick();
    rx = 5'd2; ry = 5'd3; rw = 5'd4; rh = 5'd5;
    start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    tick();
    compared++;
    if (cRdEn !== 1'b1 || cAddr !== 10'd202) begin
      mismatched++;
      $display("FAIL midrst rdC: got en=%0b addr=%0d want 1 202", cRdEn, cAddr);
    end
    rstN = 1'b0;
    tick();
    rstN = 1'b1;
    compared++;
    if (cReady !== 1'b1 || cRdEn !== 1'b0 || cValid !== 1'b0 || cSum !== 21'd0) begin
      mismatched++;
      $display("FAIL midrst state: got rdy=%0b en=%0b v=%0b sum=%0d want 1 0 0 0", cReady, cRdEn, cValid, cSum);
    end
    for (int k = 0; k < 5; k++) begin
      tick();
      compared++;
      if (cValid !== 1'b0 || cReady !== 1'b1) begin
        mismatched++;
        $display("FAIL midrst quiet%0d: got valid=%0b ready=%0b want 0 1", k, cValid, cReady);
      end
    end
    doReq("midrst_next", 5'd2, 5'd3, 5'd4, 5'd5, 10'd77, 10'd81, 10'd202, 10'd206, 21'd20, 1, 1'b0);
    checkPulseEnd("midrst_next", 21'd20);
  endtask

  task automatic test_lat3();
    mode = 0; sel = 1'b1;
    tick();
    doReq("lat3", 5'd2, 5'd3, 5'd4, 5'd5, 10'd77, 10'd81, 10'd202, 10'd206, 21'd20, 3, 1'b0);
    checkPulseEnd("lat3", 21'd20);
    sel = 1'b0;
  endtask

  initial begin
    test_reset();
    test_single();
    test_full();
    test_wrap();
    test_oob();
    test_hold_start();
    test_back_to_back();
    test_reset_mid();
    test_lat3();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
